// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit slice per stage,
// carry registered between stages, valid/ready handshake on both sides.
module rca_pipe_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSTG = (SEG == 0) ? 1 : WIDTH / SEG;
  localparam int unsigned REM  = (SEG == 0) ? 1 : WIDTH % SEG;
  localparam int unsigned SW   = SEG + 1;
  localparam int unsigned LAST = NSTG - 1;

  // Reject geometries that cannot be split into whole segments
  if ((SEG < 1) || (SEG > WIDTH) || (REM != 0)) begin : g_param_check
    $error("rca_pipe_adder: WIDTH must be a non-zero multiple of SEG");
  end

  // Stage registers: operands skew forward, finished low sum slices ride along
  logic [WIDTH-1:0] a_q [NSTG];
  logic [WIDTH-1:0] b_q [NSTG];
  logic [WIDTH-1:0] s_q [NSTG];
  logic             c_q [NSTG];
  logic             v_q [NSTG];
  logic             ovf_q;

  // Per-stage combinational views of what each stage consumes and produces
  logic [WIDTH-1:0] a_in  [NSTG];
  logic [WIDTH-1:0] b_in  [NSTG];
  logic [WIDTH-1:0] s_in  [NSTG];
  logic [WIDTH-1:0] s_nxt [NSTG];
  logic             c_in  [NSTG];
  logic             v_in  [NSTG];
  logic [SEG:0]     seg_res [NSTG];
  logic             ovf_nxt;
  logic             adv;

  // Whole pipe advances together unless the output slot is full and blocked
  assign adv      = !v_q[LAST] || out_ready;
  assign in_ready = adv;

  // Stage inputs: stage 0 sees the conditioned operands, later stages see registers
  always_comb begin
    a_in[0] = a;
    b_in[0] = sub ? ~b : b;
    c_in[0] = cin ^ sub;
    v_in[0] = in_valid;
    s_in[0] = '0;
    for (int unsigned k = 1; k < NSTG; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
      s_in[k] = s_q[k-1];
    end
  end

  // Slice adders: each stage fills in its own SEG bits of the running sum
  always_comb begin
    for (int unsigned k = 0; k < NSTG; k++) begin
      seg_res[k] = SW'(a_in[k][k*SEG +: SEG])
                 + SW'(b_in[k][k*SEG +: SEG])
                 + SW'(c_in[k]);
      s_nxt[k] = s_in[k];
      s_nxt[k][k*SEG +: SEG] = seg_res[k][SEG-1:0];
    end
    // Carry into the MSB is a^b^s at that bit; overflow is it XOR carry out
    ovf_nxt = a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1]
            ^ s_nxt[LAST][WIDTH-1] ^ seg_res[LAST][SEG];
  end

  // Pipeline registers; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NSTG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < NSTG; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_nxt[k];
        c_q[k] <= seg_res[k][SEG];
        v_q[k] <= v_in[k];
      end
      ovf_q <= ovf_nxt;
    end
  end

  // Result leaves straight from the last stage registers
  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

endmodule
